// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
// Requester-side bundle of the video SRAM arbiter: display fetch port, host
// read port, host write port and the Busy flag. The board SRAM pins are not
// part of this bundle; they stay plain ports on the arbiter so that the data
// bus remains a true top-level inout.
//   master : requester side (pixel pipeline + host bus)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              DispReq;
    logic [ADDR_W-1:0] DispAddr;
    logic [DATA_W-1:0] DispData;
    logic              DispRdy;

    logic              HostRdReq;
    logic [ADDR_W-1:0] HostRdAddr;
    logic [DATA_W-1:0] HostRdData;
    logic              HostRdRdy;

    logic              HostWrReq;
    logic [ADDR_W-1:0] HostWrAddr;
    logic [DATA_W-1:0] HostWrData;
    logic              HostWrRdy;

    logic              Busy;

    modport master (
        output DispReq, DispAddr, HostRdReq, HostRdAddr,
               HostWrReq, HostWrAddr, HostWrData,
        input  DispData, DispRdy, HostRdData, HostRdRdy, HostWrRdy, Busy
    );

    modport slave (
        input  DispReq, DispAddr, HostRdReq, HostRdAddr,
               HostWrReq, HostWrAddr, HostWrData,
        output DispData, DispRdy, HostRdData, HostRdRdy, HostWrRdy, Busy
    );
endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one external asynchronous video SRAM between the display fetch port
// (fixed top priority) and the host read/write ports (round-robin between
// them). Every access runs IDLE -> SETUP -> ACCESS (ACCESS_CYCLES clocks) ->
// RECOVER -> IDLE; all pin and handshake outputs are registered.
//
// Ports
//   MemClk          memory clock, rising edge
//   MemRstN         asynchronous active-low reset
//   bus             requester handshakes (vram_arbiter_if.slave)
//   MemAddrPort     SRAM address
//   MemDataPort     SRAM data, driven only SETUP..RECOVER of a write
//   MemWriteEnable  SRAM WE, active-low
//   MemOutputEnable SRAM OE, active-low
//
// Build option
//   VRAM_ARB_STARVE_GUARD_EN : after STARVE_LIMIT consecutive display grants
//   made while a host request waits, the next arbitration goes to the host.
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              MemClk,
    input  logic              MemRstN,
    vram_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] MemAddrPort,
    inout  wire  [DATA_W-1:0] MemDataPort,
    output logic              MemWriteEnable,
    output logic              MemOutputEnable
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_e;
    typedef enum logic [1:0] {P_DISP, P_HRD, P_HWR}        port_e;

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    state_e            state_q;
    port_e             port_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drv_q;
    logic              we_n_q, oe_n_q;
    logic [DATA_W-1:0] disp_data_q, hrd_data_q;
    logic              disp_rdy_q, hrd_rdy_q, hwr_rdy_q;
    logic              busy_q;
    logic              rr_q;        // 0: host read preferred, 1: host write

    logic              any_host_d, disp_win_d, gvld_d;
    port_e             gport_d;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q;
`else
    // Parameter kept so both builds share one instantiation signature.
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    // Grant decision, consumed only in IDLE.
    always_comb begin
        any_host_d = bus.HostRdReq | bus.HostWrReq;
        disp_win_d = bus.DispReq;
`ifdef VRAM_ARB_STARVE_GUARD_EN
        if (any_host_d && starve_q == STARVE_W'(STARVE_LIMIT))
            disp_win_d = 1'b0;
`endif
        if (disp_win_d)
            gport_d = P_DISP;
        else if (bus.HostRdReq && (!bus.HostWrReq || !rr_q))
            gport_d = P_HRD;
        else
            gport_d = P_HWR;
        gvld_d = bus.DispReq | any_host_d;
    end

    always_ff @(posedge MemClk or negedge MemRstN) begin
        if (!MemRstN) begin
            state_q     <= IDLE;
            port_q      <= P_DISP;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            drv_q       <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            disp_data_q <= '0;
            hrd_data_q  <= '0;
            disp_rdy_q  <= 1'b0;
            hrd_rdy_q   <= 1'b0;
            hwr_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            rr_q        <= 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
            starve_q    <= '0;
`endif
        end else begin
            disp_rdy_q <= 1'b0;
            hrd_rdy_q  <= 1'b0;
            hwr_rdy_q  <= 1'b0;
            case (state_q)
                IDLE: if (gvld_d) begin
                    state_q <= SETUP;
                    busy_q  <= 1'b1;
                    port_q  <= gport_d;
                    case (gport_d)
                        P_DISP:  addr_q <= bus.DispAddr;
                        P_HRD:   addr_q <= bus.HostRdAddr;
                        default: begin
                            addr_q  <= bus.HostWrAddr;
                            wdata_q <= bus.HostWrData;
                        end
                    endcase
                    // Reads open OE at SETUP; writes start driving data at SETUP
                    // so it is settled well before WE falls.
                    oe_n_q <= (gport_d == P_HWR);
                    drv_q  <= (gport_d == P_HWR);
                    if (gport_d != P_DISP)
                        rr_q <= ~rr_q;
`ifdef VRAM_ARB_STARVE_GUARD_EN
                    if (gport_d != P_DISP || !any_host_d)
                        starve_q <= '0;
                    else
                        starve_q <= starve_q + 1'b1;
`endif
                end
                SETUP: begin
                    state_q <= ACCESS;
                    cnt_q   <= CNT_W'(ACCESS_CYCLES - 1);
                    if (port_q == P_HWR)
                        we_n_q <= 1'b0;
                end
                ACCESS: if (cnt_q == '0) begin
                    // Last strobe clock: capture read data, close strobes and
                    // raise Rdy together so Rdy and data appear in RECOVER.
                    state_q <= RECOVER;
                    we_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    case (port_q)
                        P_DISP: begin
                            disp_data_q <= MemDataPort;
                            disp_rdy_q  <= 1'b1;
                        end
                        P_HRD: begin
                            hrd_data_q <= MemDataPort;
                            hrd_rdy_q  <= 1'b1;
                        end
                        default: hwr_rdy_q <= 1'b1;
                    endcase
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RECOVER: begin
                    // Address and write data stay put through RECOVER for hold.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    drv_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MemAddrPort     = addr_q;
    assign MemDataPort     = drv_q ? wdata_q : {DATA_W{1'bz}};
    assign MemWriteEnable  = we_n_q;
    assign MemOutputEnable = oe_n_q;

    assign bus.DispData    = disp_data_q;
    assign bus.DispRdy     = disp_rdy_q;
    assign bus.HostRdData  = hrd_data_q;
    assign bus.HostRdRdy   = hrd_rdy_q;
    assign bus.HostWrRdy   = hwr_rdy_q;
    assign bus.Busy        = busy_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Directed and randomized transactions against vram_arbiter with a small SRAM
// model on the pins. Expected grant order, Rdy timing and read data come from
// a transaction-level model (priority + round-robin pointer + reference memory).
// -----------------------------------------------------------------------------
module tb_vram_arbiter;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int N      = 2;
    localparam int LIM    = 4;

    logic MemClk  = 1'b0;
    logic MemRstN = 1'b0;
    always #5 MemClk = ~MemClk;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [ADDR_W-1:0] MemAddrPort;
    wire  [DATA_W-1:0] MemDataPort;
    logic              MemWriteEnable;
    logic              MemOutputEnable;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ACCESS_CYCLES(N), .STARVE_LIMIT(LIM)
    ) dut (
        .MemClk         (MemClk),
        .MemRstN        (MemRstN),
        .bus            (bus),
        .MemAddrPort    (MemAddrPort),
        .MemDataPort    (MemDataPort),
        .MemWriteEnable (MemWriteEnable),
        .MemOutputEnable(MemOutputEnable)
    );

    // SRAM model: 1K bytes aliased on the low address bits.
    logic [7:0] sram [0:1023];
    always @(posedge MemClk)
        if (!MemWriteEnable) sram[MemAddrPort[9:0]] <= MemDataPort;
    assign MemDataPort = !MemOutputEnable ? sram[MemAddrPort[9:0]] : 8'hzz;

    // Reference model state.
    logic [7:0]        ref_mem [0:1023];
    logic [ADDR_W-1:0] written [$];
    bit                rr_exp;        // 0: read next, 1: write next
    logic [7:0]        last_disp_exp, last_hrd_exp;
    int                total = 0;
    int                bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.DispReq   = 1'b0;
        bus.HostRdReq = 1'b0;
        bus.HostWrReq = 1'b0;
    endtask

    // Raise a set of requests together, hold each until its Rdy, and compare
    // grant order, Rdy spacing and read data with the model.
    task automatic do_batch(input bit d, input bit r, input bit w,
                            input logic [ADDR_W-1:0] da, input logic [ADDR_W-1:0] ra,
                            input logic [ADDR_W-1:0] wa, input logic [7:0] wd);
        int         exp_q [$];
        logic [7:0] exp_d [$];
        int         got, cyc, last_cyc, nr, port;
        if (d) begin exp_q.push_back(0); exp_d.push_back(ref_mem[da[9:0]]); end
        if (r && w) begin
            if (!rr_exp) begin
                exp_q.push_back(1); exp_d.push_back(ref_mem[ra[9:0]]);
                exp_q.push_back(2); exp_d.push_back(wd); ref_mem[wa[9:0]] = wd;
            end else begin
                exp_q.push_back(2); exp_d.push_back(wd); ref_mem[wa[9:0]] = wd;
                exp_q.push_back(1); exp_d.push_back(ref_mem[ra[9:0]]);
            end
        end else if (r) begin
            exp_q.push_back(1); exp_d.push_back(ref_mem[ra[9:0]]); rr_exp = ~rr_exp;
        end else if (w) begin
            exp_q.push_back(2); exp_d.push_back(wd); ref_mem[wa[9:0]] = wd; rr_exp = ~rr_exp;
        end
        if (w) written.push_back(wa);

        @(negedge MemClk);
        check("idle_busy", bus.Busy, 0);
        check("disp_hold", bus.DispData, last_disp_exp);
        check("hrd_hold", bus.HostRdData, last_hrd_exp);
        bus.DispAddr = da; bus.HostRdAddr = ra; bus.HostWrAddr = wa; bus.HostWrData = wd;
        bus.DispReq = d; bus.HostRdReq = r; bus.HostWrReq = w;
        got = 0; cyc = 0; last_cyc = 0;
        while (got < exp_q.size() && cyc < 20 * (N + 3)) begin
            @(negedge MemClk);
            cyc++;
            nr = int'(bus.DispRdy) + int'(bus.HostRdRdy) + int'(bus.HostWrRdy);
            if (nr > 0) begin
                port = bus.DispRdy ? 0 : (bus.HostRdRdy ? 1 : 2);
                check("rdy_onehot", nr, 1);
                check("grant_port", port, exp_q[got]);
                check("rdy_time", cyc - last_cyc, (got == 0) ? N + 2 : N + 3);
                if (port == 0) begin
                    check("disp_data", bus.DispData, exp_d[got]);
                    last_disp_exp = exp_d[got];
                    bus.DispReq = 1'b0;
                end else if (port == 1) begin
                    check("hrd_data", bus.HostRdData, exp_d[got]);
                    last_hrd_exp = exp_d[got];
                    bus.HostRdReq = 1'b0;
                end else begin
                    bus.HostWrReq = 1'b0;
                end
                last_cyc = cyc;
                got++;
            end
        end
        check("batch_done", got, exp_q.size());
        clear_reqs();
    endtask

    initial begin
        int         got, cyc, welow, dcnt, hcnt, rdy, alt_exp [3];
        logic [ADDR_W-1:0] da, ra, wa;
        logic [7:0] wd;
        bit         d, r, w;

        clear_reqs();
        bus.DispAddr = '0; bus.HostRdAddr = '0; bus.HostWrAddr = '0; bus.HostWrData = '0;
        rr_exp = 1'b0; last_disp_exp = 8'h00; last_hrd_exp = 8'h00;

        // ---- reset values
        repeat (3) @(negedge MemClk);
        check("rst_we", MemWriteEnable, 1);
        check("rst_oe", MemOutputEnable, 1);
        check("rst_addr", MemAddrPort, 0);
        check("rst_rdy", {bus.DispRdy, bus.HostRdRdy, bus.HostWrRdy}, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_data", {bus.DispData, bus.HostRdData}, 0);
        MemRstN = 1'b1;

        // ---- read and write held together: read, write, read
        @(negedge MemClk);
        bus.HostRdAddr = 19'h00200; bus.HostWrAddr = 19'h00200; bus.HostWrData = 8'hC3;
        bus.HostRdReq = 1'b1; bus.HostWrReq = 1'b1;
        alt_exp[0] = 1; alt_exp[1] = 2; alt_exp[2] = 1;
        got = 0; cyc = 0;
        while (got < 3 && cyc < 100) begin
            @(negedge MemClk);
            cyc++;
            if (bus.HostRdRdy || bus.HostWrRdy) begin
                check("alt_order", bus.HostWrRdy ? 2 : 1, alt_exp[got]);
                got++;
                if (got == 3) clear_reqs();
            end
        end
        check("alt_done", got, 3);
        check("alt_rd_data", bus.HostRdData, 8'hC3);
        ref_mem[10'h200] = 8'hC3; written.push_back(19'h00200);
        last_hrd_exp = 8'hC3; rr_exp = 1'b1;

        // ---- host write waveform, 0x00012 <= 0xA5
        @(negedge MemClk);
        bus.HostWrAddr = 19'h00012; bus.HostWrData = 8'hA5; bus.HostWrReq = 1'b1;
        welow = 0;
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge MemClk);
            if (k <= N + 2) begin
                check("wr_addr", MemAddrPort, 19'h00012);
                check("wr_data", MemDataPort, 8'hA5);
                check("wr_oe", MemOutputEnable, 1);
                check("wr_busy", bus.Busy, 1);
                check("wr_we", MemWriteEnable, (k >= 2 && k <= N + 1) ? 0 : 1);
                check("wr_rdy", bus.HostWrRdy, (k == N + 2) ? 1 : 0);
            end else begin
                check("wr_rdy_end", bus.HostWrRdy, 0);
                check("wr_busy_end", bus.Busy, 0);
                check("wr_we_end", MemWriteEnable, 1);
            end
            if (!MemWriteEnable) welow++;
            if (bus.HostWrRdy) bus.HostWrReq = 1'b0;
        end
        check("wr_we_len", welow, N);
        ref_mem[10'h012] = 8'hA5; written.push_back(19'h00012); rr_exp = ~rr_exp;

        // ---- read back, then display and host read together
        do_batch(0, 1, 0, 19'h0, 19'h00012, 19'h0, 8'h00);
        do_batch(1, 1, 0, 19'h00012, 19'h00200, 19'h0, 8'h00);

        // ---- display held high while host read waits
        @(negedge MemClk);
        bus.DispAddr = 19'h00200; bus.HostRdAddr = 19'h00012;
        bus.DispReq = 1'b1; bus.HostRdReq = 1'b1;
        dcnt = 0; hcnt = 0; cyc = 0;
        while (hcnt == 0 && cyc < 20 * (N + 3)) begin
            @(negedge MemClk);
            cyc++;
            if (bus.DispRdy) begin
                dcnt++;
`ifndef VRAM_ARB_STARVE_GUARD_EN
                if (dcnt == 6) begin
                    check("nostarve_no_host", hcnt, 0);
                    bus.DispReq = 1'b0;
                end
`endif
            end
            if (bus.HostRdRdy) begin
                hcnt++;
                clear_reqs();
            end
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        check("starve_disp_before_host", dcnt, LIM);
`else
        check("nostarve_disp_before_host", dcnt, 6);
`endif
        check("starve_host_done", hcnt, 1);
        check("starve_hrd_data", bus.HostRdData, ref_mem[10'h012]);
        check("starve_disp_data", bus.DispData, ref_mem[10'h200]);
        last_hrd_exp = ref_mem[10'h012]; last_disp_exp = ref_mem[10'h200];
        rr_exp = ~rr_exp;
        clear_reqs();

        // ---- randomized request mixes
        for (int it = 0; it < 25; it++) begin
            d = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!(d || r || w)) w = 1'b1;
            da = written[$urandom_range(0, written.size() - 1)];
            ra = written[$urandom_range(0, written.size() - 1)];
            wa = ADDR_W'($urandom());
            wd = 8'($urandom());
            do_batch(d, r, w, da, ra, wa, wd);
        end

        // ---- reset during a write strobe
        @(negedge MemClk);
        bus.HostWrAddr = 19'h00155; bus.HostWrData = 8'h5A; bus.HostWrReq = 1'b1;
        @(negedge MemClk);
        @(negedge MemClk);
        check("abort_we_low", MemWriteEnable, 0);
        #2 MemRstN = 1'b0;
        bus.HostWrReq = 1'b0;
        #1;
        check("abort_we_async", MemWriteEnable, 1);
        check("abort_oe_async", MemOutputEnable, 1);
        check("abort_busy", bus.Busy, 0);
        check("abort_addr", MemAddrPort, 0);
        @(negedge MemClk);
        MemRstN = 1'b1;
        rdy = 0;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge MemClk);
            if (bus.HostWrRdy) rdy++;
        end
        check("abort_no_rdy", rdy, 0);
        check("abort_idle", bus.Busy, 0);
        last_disp_exp = 8'h00; last_hrd_exp = 8'h00; rr_exp = 1'b0;

        do_batch(0, 0, 1, 19'h0, 19'h0, 19'h00155, 8'h3C);
        do_batch(0, 1, 0, 19'h0, 19'h00155, 19'h0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
